// File: rtl/module_fsm_luces_n.sv
// ---------------------------------------------------------------------------
// module_fsm_luces_n
//
// N-room apartment light controller with internal timers. A door button lights
// the lobby; selecting exactly one room while the lobby window is open lights
// that room. The next press turns everything off. No external timer needed.
//
// Build option:
//   AUTO_OFF_EN  when defined, a lit room switches itself off after
//                ROOM_CYCLES idle cycles. When undefined the room stays lit
//                until the next press and ROOM_CYCLES only sizes the counter.
//
// Ports:
//   clk_i       in   1        system clock
//   rst_i       in   1        asynchronous active-low reset
//   p_i         in   N_ROOMS  button levels, synchronised and debounced
//   lobby_o     out  1        lobby light
//   room_o      out  N_ROOMS  room lights, one-hot or zero
//   tmr_en_o    out  1        high while the lobby window timer counts
//   room_idx_o  out  IDX_W    index of the selected room, held after exit
//   state_o     out  3        encoded state for debug/LED
// ---------------------------------------------------------------------------
module module_fsm_luces_n #(
  parameter int unsigned N_ROOMS      = 2,
  parameter int unsigned LOBBY_CYCLES = 50_000_000,
  parameter int unsigned ROOM_CYCLES  = 500_000_000,
  localparam int unsigned IDX_W       = (N_ROOMS > 1) ? $clog2(N_ROOMS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_ROOMS-1:0] p_i,
  output logic               lobby_o,
  output logic [N_ROOMS-1:0] room_o,
  output logic               tmr_en_o,
  output logic [IDX_W-1:0]   room_idx_o,
  output logic [2:0]         state_o
);

  localparam int unsigned CNT_MAX_CYCLES =
      (LOBBY_CYCLES > ROOM_CYCLES) ? LOBBY_CYCLES : ROOM_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] LOBBY_LAST = CNT_W'(LOBBY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
`ifdef AUTO_OFF_EN
  localparam logic [CNT_W-1:0] ROOM_LAST  = CNT_W'(ROOM_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLobby = 3'd1,
    StWait  = 3'd2,
    StEnter = 3'd3,
    StRoom  = 3'd4,
    StExit  = 3'd5
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [IDX_W-1:0] r_room_idx;
  logic [IDX_W-1:0] w_room_idx_d;

  logic             w_any;
  logic             w_one;
  logic [IDX_W-1:0] w_k;
  logic [CNT_W-1:0] w_cnt_inc;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  assign w_any = |p_i;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_one = w_any && ((p_i & (p_i - 1'b1)) == '0);

  always_comb begin
    w_k = '0;
    for (int i = 0; i < int'(N_ROOMS); i++) begin
      if (p_i[i]) begin
        w_k = IDX_W'(i);
      end
    end
  end

  // Saturating increment so the counter can never wrap.
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_room_idx <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_room_idx <= w_room_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_room_idx_d = r_room_idx;

    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_d = StLobby;
        end
      end

      StLobby: begin
        if (!w_any) begin
          w_state_d = StWait;
          w_cnt_d   = '0;
        end
      end

      StWait: begin
        w_cnt_d = w_cnt_inc;
        // A single press beats the timeout on the expiry cycle; multi-press is
        // ignored and the window keeps running.
        if (w_one) begin
          w_state_d    = StEnter;
          w_room_idx_d = w_k;
        end else if (r_cnt == LOBBY_LAST) begin
          w_state_d = StIdle;
        end
      end

      StEnter: begin
        // Wait for the selecting press to be released so it cannot double as
        // the exit press.
        if (!w_any) begin
          w_state_d = StRoom;
          w_cnt_d   = '0;
        end
      end

      StRoom: begin
`ifdef AUTO_OFF_EN
        w_cnt_d = w_cnt_inc;
        if (w_any) begin
          w_state_d = StExit;
        end else if (r_cnt == ROOM_LAST) begin
          w_state_d = StIdle;
        end
`else
        if (w_any) begin
          w_state_d = StExit;
        end
`endif
      end

      StExit: begin
        // A held button must be released first so it never re-lights the lobby.
        if (!w_any) begin
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    lobby_o  = 1'b0;
    tmr_en_o = 1'b0;
    room_o   = '0;

    case (r_state)
      StLobby: begin
        lobby_o = 1'b1;
      end
      StWait: begin
        lobby_o  = 1'b1;
        tmr_en_o = 1'b1;
      end
      StEnter, StRoom: begin
        for (int i = 0; i < int'(N_ROOMS); i++) begin
          room_o[i] = (r_room_idx == IDX_W'(i));
        end
      end
      default: begin
        lobby_o  = 1'b0;
        tmr_en_o = 1'b0;
        room_o   = '0;
      end
    endcase
  end

  assign room_idx_o = r_room_idx;
  assign state_o    = r_state;

endmodule

// File: tb/tb_module_fsm_luces_n.sv
// ---------------------------------------------------------------------------
// tb_module_fsm_luces_n
//
// Bench for module_fsm_luces_n with N_ROOMS=3, LOBBY_CYCLES=8, ROOM_CYCLES=16.
// A behavioural model using countdown timers predicts every output each cycle;
// directed scenarios are followed by randomized button sequences.
// ---------------------------------------------------------------------------
module tb_module_fsm_luces_n;

  localparam int unsigned NR   = 3;
  localparam int unsigned LOBC = 8;
  localparam int unsigned ROOC = 16;
  localparam int unsigned IW   = 2;

  // Model phases, numbered as the debug state output reports them.
  localparam int PH_IDLE  = 0;
  localparam int PH_LOBBY = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_ENTER = 3;
  localparam int PH_ROOM  = 4;
  localparam int PH_EXIT  = 5;

  logic          clk_i;
  logic          rst_i;
  logic [NR-1:0] p_i;
  logic          lobby_o;
  logic [NR-1:0] room_o;
  logic          tmr_en_o;
  logic [IW-1:0] room_idx_o;
  logic [2:0]    state_o;

  module_fsm_luces_n #(
    .N_ROOMS      (NR),
    .LOBBY_CYCLES (LOBC),
    .ROOM_CYCLES  (ROOC)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .p_i        (p_i),
    .lobby_o    (lobby_o),
    .room_o     (room_o),
    .tmr_en_o   (tmr_en_o),
    .room_idx_o (room_idx_o),
    .state_o    (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec;
  int n_err;

  // Reference model state
  int m_ph;
  int m_left;   // cycles remaining in the current timed window
  int m_idx;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph   = PH_IDLE;
    m_left = 0;
    m_idx  = 0;
  endtask

  task automatic model_step(input logic [NR-1:0] p);
    int  ones;
    bit  any;
    ones = $countones(p);
    any  = (p != '0);
    case (m_ph)
      PH_IDLE:  if (any) m_ph = PH_LOBBY;
      PH_LOBBY: if (!any) begin m_ph = PH_WAIT; m_left = LOBC; end
      PH_WAIT: begin
        if (ones == 1) begin
          m_ph = PH_ENTER;
          for (int i = 0; i < int'(NR); i++) if (p[i]) m_idx = i;
        end else if (m_left == 1) begin
          m_ph = PH_IDLE;
        end else begin
          m_left--;
        end
      end
      PH_ENTER: if (!any) begin m_ph = PH_ROOM; m_left = ROOC; end
      PH_ROOM: begin
        if (any) m_ph = PH_EXIT;
`ifdef AUTO_OFF_EN
        else if (m_left == 1) m_ph = PH_IDLE;
        else m_left--;
`endif
      end
      PH_EXIT:  if (!any) m_ph = PH_IDLE;
      default:  m_ph = PH_IDLE;
    endcase
  endtask

  task automatic check_all();
    int unsigned exp_room;
    exp_room = (m_ph == PH_ENTER || m_ph == PH_ROOM) ? (32'd1 << m_idx) : 32'd0;
    check("state", 32'(state_o), 32'(m_ph));
    check("lobby", 32'(lobby_o), 32'((m_ph == PH_LOBBY) || (m_ph == PH_WAIT)));
    check("tmr_en", 32'(tmr_en_o), 32'(m_ph == PH_WAIT));
    check("room", 32'(room_o), exp_room);
    check("room_idx", 32'(room_idx_o), 32'(m_idx));
    check("excl", 32'(lobby_o && (room_o != '0)), 32'd0);
  endtask

  // Apply one input vector for one clock, advance the model, compare #1 later.
  task automatic step(input logic [NR-1:0] p);
    p_i = p;
    @(posedge clk_i);
    model_step(p);
    #1;
    check_all();
  endtask

  task automatic go_idle();
    for (int i = 0; i < 40; i++) begin
      if (m_ph == PH_IDLE) break;
      if (m_ph == PH_ROOM) step(3'b001);
      else step(3'b000);
    end
    check("go_idle", 32'(state_o), 32'(PH_IDLE));
  endtask

  task automatic go_room(input int k);
    logic [NR-1:0] b;
    go_idle();
    b = NR'(1 << k);
    step(b);
    step(3'b000);
    step(b);
    step(3'b000);
  endtask

  initial begin
    int            n_tmr;
    logic [NR-1:0] rp;
    int            hold;
    int            pick;

    n_vec = 0;
    n_err = 0;
    p_i   = '0;
    rst_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_all();

    // Async reset in the middle of ROOM clears outputs without a clock edge.
    go_room(1);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_room", 32'(room_o), 32'd0);
    check("rst_lobby", 32'(lobby_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_idx", 32'(room_idx_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_all();

    // Lobby window lasts exactly LOBC cycles.
    step(3'b001);
    step(3'b001);
    step(3'b000);
    n_tmr = 0;
    for (int i = 0; i < 20; i++) begin
      if (tmr_en_o && lobby_o) n_tmr++;
      step(3'b000);
    end
    check("t_len", 32'(n_tmr), LOBC);
    check("t_off", 32'(lobby_o), 32'd0);

    // Select room 2 at cnt=3, then exit with a different button.
    go_idle();
    step(3'b001);
    step(3'b000);
    repeat (3) step(3'b000);
    step(3'b100);
    check("sel_room", 32'(room_o), 32'b100);
    check("sel_idx", 32'(room_idx_o), 32'd2);
    step(3'b000);
    step(3'b010);
    check("exit_room", 32'(room_o), 32'd0);
    check("exit_state", 32'(state_o), 32'(PH_EXIT));
    step(3'b000);
    check("exit_idle", 32'(state_o), 32'(PH_IDLE));

    // Multi-press ignored; single press on the expiry cycle wins.
    step(3'b001);
    step(3'b000);
    repeat (7) step(3'b011);
    step(3'b010);
    check("mp_state", 32'(state_o), 32'(PH_ENTER));
    check("mp_idx", 32'(room_idx_o), 32'd1);

    // Room hold / auto-off.
    go_room(0);
`ifdef AUTO_OFF_EN
    repeat (ROOC) step(3'b000);
    check("auto_off", 32'(room_o), 32'd0);
`else
    repeat (100) step(3'b000);
    check("room_hold", 32'(room_o), 32'b001);
`endif

    // Held exit press never re-lights the lobby.
    go_room(2);
    step(3'b001);
    repeat (5) begin
      step(3'b001);
      check("hx_state", 32'(state_o), 32'(PH_EXIT));
      check("hx_lobby", 32'(lobby_o), 32'd0);
    end
    step(3'b000);
    check("hx_idle", 32'(state_o), 32'(PH_IDLE));

    // Randomized button sequences.
    for (int s = 0; s < 400; s++) begin
      pick = int'($urandom_range(99));
      if (pick < 50)      rp = '0;
      else if (pick < 85) rp = NR'(1 << $urandom_range(NR - 1));
      else                rp = NR'($urandom_range(7));
      hold = int'($urandom_range(12, 1));
      repeat (hold) step(rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
